square_arbiter: RTL and testbench

Round-robin scheduler that shares one combinational `square_gen` squarer among REQS requesters. It accepts one operand at a time through a req/grant handshake and registers the operand into the squarer. It returns the 2N-bit square with the originating requester ID over a valid/ready output port. The block sits between the operand producers and the single squarer instance it contains.

---
 rtl/square_arbiter_if.sv | 36 +++
 rtl/square_arbiter.sv | 135 +++++++++++++
 tb/tb_square_arbiter.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/square_arbiter_if.sv
// square_arbiter_if
//   Bundles the requester-side and result-side signals of square_arbiter.
//   master : operand producers / result consumer (drive req, num_bus, out_ready)
//   slave  : the arbiter itself (drives grant, out, out_id, out_valid)
//   Signals:
//     req[REQS]        per-requester request level
//     num_bus[REQS*N]  packed operands, requester i owns [i*N +: N]
//     grant[REQS]      one-hot, one-cycle capture acknowledge
//     out[2N]          squared result
//     out_id[IDW]      requester index of out
//     out_valid        result valid
//     out_ready        consumer accepts result
interface square_arbiter_if #(
    parameter int N    = 4,
    parameter int REQS = 4
);
    localparam int IDW = (REQS > 1) ? $clog2(REQS) : 1;

    logic [REQS-1:0]   req;
    logic [REQS*N-1:0] num_bus;
    logic [REQS-1:0]   grant;
    logic [2*N-1:0]    out;
    logic [IDW-1:0]    out_id;
    logic              out_valid;
    logic              out_ready;

    modport master (
        output req, num_bus, out_ready,
        input  grant, out, out_id, out_valid
    );

    modport slave (
        input  req, num_bus, out_ready,
        output grant, out, out_id, out_valid
    );
endinterface

// File: rtl/square_arbiter.sv
// square_arbiter
//   Round-robin scheduler sharing one combinational squarer among REQS
//   requesters. One operand is captured per transaction (IDLE), squared
//   (CALC) and presented with its requester ID until accepted (HOLD).
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset
//     bus    square_arbiter_if.slave (req/num_bus in, grant/out/out_id/
//            out_valid out, out_ready in)

// Combinational N-bit squarer, full 2N-bit result.
module square_gen #(
    parameter int N = 4
) (
    input  logic [N-1:0]   a,
    output logic [2*N-1:0] sq
);
    logic [2*N-1:0] a_ext;

    assign a_ext = {{N{1'b0}}, a};
    assign sq    = a_ext * a_ext;
endmodule

module square_arbiter #(
    parameter int N    = 4,
    parameter int REQS = 4
) (
    input logic            clk,
    input logic            rst_n,
    square_arbiter_if.slave bus
);
    localparam int IDW = (REQS > 1) ? $clog2(REQS) : 1;

    typedef enum logic [1:0] {IDLE, CALC, HOLD} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [N-1:0]     op_reg;
    logic [IDW-1:0]   id_reg;
    logic [IDW-1:0]   ptr;
    logic [IDW-1:0]   ptr_inc;
    logic [IDW-1:0]   win;
    logic             found;
    logic [N-1:0]     win_op;
    logic [REQS-1:0]  grant_nxt;
    logic [2*N-1:0]   sq;

    square_gen #(.N(N)) u_square_gen (
        .a  (op_reg),
        .sq (sq)
    );

    // Rotating priority scan: ptr has highest priority, then ptr+1, ...
    // wrapping at REQS. The first set request bit wins.
    always_comb begin
        win   = '0;
        found = 1'b0;
        for (int k = 0; k < REQS; k++) begin
            if (!found && bus.req[(int'(ptr) + k) % REQS]) begin
                win   = IDW'((int'(ptr) + k) % REQS);
                found = 1'b1;
            end
        end
    end

    assign win_op = bus.num_bus[int'(win)*N +: N];

    // The just-served requester drops to lowest priority.
    assign ptr_inc = (int'(id_reg) == REQS - 1) ? '0 : id_reg + 1'b1;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (found)         state_nxt = CALC;
            CALC:                       state_nxt = HOLD;
            HOLD:    if (bus.out_ready) state_nxt = IDLE;
            default:                    state_nxt = IDLE;
        endcase
    end

    // Output logic: grant pulse only leaves IDLE with a winner.
    always_comb begin
        grant_nxt = '0;
        if (state == IDLE && found) begin
            grant_nxt = REQS'(1) << win;
        end
    end

    // Registered datapath and outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_reg        <= '0;
            id_reg        <= '0;
            ptr           <= '0;
            bus.grant     <= '0;
            bus.out       <= '0;
            bus.out_id    <= '0;
            bus.out_valid <= 1'b0;
        end else begin
            bus.grant <= grant_nxt;
            case (state)
                IDLE: begin
                    if (found) begin
                        op_reg <= win_op;
                        id_reg <= win;
                    end
                end
                CALC: begin
                    bus.out       <= sq;
                    bus.out_id    <= id_reg;
                    bus.out_valid <= 1'b1;
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        ptr           <= ptr_inc;
                    end
                end
                default: begin
                    bus.out_valid <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_square_arbiter.sv
// tb_square_arbiter
//   Directed bench for square_arbiter with hand-computed expected values.
module tb_square_arbiter;
    localparam int N    = 4;
    localparam int REQS = 4;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    square_arbiter_if #(.N(N), .REQS(REQS)) bus ();

    square_arbiter #(.N(N), .REQS(REQS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic set_op(input int id, input int op);
        bus.num_bus[id*N +: N] = N'(op);
    endtask

    // Waits (bounded) for a grant, then checks it is for requester id.
    task automatic wait_grant(input int id, output int gcyc);
        for (int k = 0; k < 12; k++) begin
            tick;
            if (bus.grant != '0) break;
        end
        chk("grant", 32'(bus.grant), 32'(1 << id));
        gcyc = cyc;
    endtask

    task automatic expect_result(input int id, input int exp);
        tick;
        chk("out_valid", 32'(bus.out_valid), 1);
        chk("out", 32'(bus.out), 32'(exp));
        chk("out_id", 32'(bus.out_id), 32'(id));
        chk("grant_low", 32'(bus.grant), 0);
    endtask

    task automatic serve(input int id, input int op, input int exp);
        int g;
        set_op(id, op);
        bus.req = 4'(1 << id);
        wait_grant(id, g);
        bus.req[id] = 1'b0;
        expect_result(id, exp);
        tick;
        chk("valid_drop", 32'(bus.out_valid), 0);
    endtask

    // Invariants checked every cycle outside reset.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("grant_vs_valid", 32'((|bus.grant) && bus.out_valid), 0);
            chk("grant_onehot", 32'($countones(bus.grant) <= 1), 1);
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int g;
        int prev;
        int exp4[4];
        exp4 = '{1, 4, 9, 16};

        rst_n         = 1'b0;
        bus.req       = '0;
        bus.num_bus   = '0;
        bus.out_ready = 1'b1;
        repeat (2) tick;
        chk("rst_grant", 32'(bus.grant), 0);
        chk("rst_out", 32'(bus.out), 0);
        chk("rst_out_id", 32'(bus.out_id), 0);
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        rst_n = 1'b1;

        // Single request and boundary operands
        serve(0, 3, 9);
        serve(2, 15, 225);
        serve(1, 0, 0);

        // All four requesting at reset exit
        rst_n = 1'b0;
        tick;
        set_op(0, 1);
        set_op(1, 2);
        set_op(2, 3);
        set_op(3, 4);
        bus.req = 4'b1111;
        rst_n   = 1'b1;
        prev    = 0;
        for (int n = 0; n < 4; n++) begin
            wait_grant(n, g);
            if (n > 0) chk("grant_gap", 32'(g - prev), 3);
            prev = g;
            bus.req[n] = 1'b0;
            expect_result(n, exp4[n]);
        end
        tick;
        chk("all4_drop", 32'(bus.out_valid), 0);

        // Wrap-around
        serve(3, 5, 25);
        set_op(0, 2);
        set_op(3, 6);
        bus.req = 4'b1001;
        wait_grant(0, g);
        bus.req[0] = 1'b0;
        expect_result(0, 4);
        wait_grant(3, g);
        bus.req[3] = 1'b0;
        expect_result(3, 36);
        tick;

        // Backpressure with requester 2 pending
        bus.out_ready = 1'b0;
        set_op(1, 7);
        bus.req = 4'b0010;
        wait_grant(1, g);
        set_op(2, 6);
        bus.req = 4'b0100;
        expect_result(1, 49);
        for (int k = 0; k < 5; k++) begin
            tick;
            chk("bp_out", 32'(bus.out), 49);
            chk("bp_id", 32'(bus.out_id), 1);
            chk("bp_valid", 32'(bus.out_valid), 1);
            chk("bp_grant", 32'(bus.grant), 0);
        end
        bus.out_ready = 1'b1;
        tick;
        chk("bp_valid_drop", 32'(bus.out_valid), 0);
        chk("bp_out_kept", 32'(bus.out), 49);
        chk("bp_grant_wait", 32'(bus.grant), 0);
        tick;
        chk("bp_next_grant", 32'(bus.grant), 32'b0100);
        bus.req = '0;
        expect_result(2, 36);
        tick;

        // Reset during CALC
        set_op(2, 9);
        bus.req = 4'b0100;
        wait_grant(2, g);
        bus.req = '0;
        rst_n   = 1'b0;
        #1;
        chk("rc_grant", 32'(bus.grant), 0);
        chk("rc_out", 32'(bus.out), 0);
        chk("rc_out_id", 32'(bus.out_id), 0);
        chk("rc_valid", 32'(bus.out_valid), 0);
        tick;
        chk("rc_valid_held", 32'(bus.out_valid), 0);
        tick;
        rst_n = 1'b1;

        // Priority pointer restarts at 0: 0 beats 3
        set_op(0, 5);
        set_op(3, 7);
        bus.req = 4'b1001;
        wait_grant(0, g);
        bus.req = '0;
        expect_result(0, 25);
        tick;
        serve(2, 9, 81);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
